ipml_pkt_fifo_sync: RTL and testbench



---
 rtl/ipml_pkt_fifo_pkg.sv | 26 ++
 rtl/ipml_pkt_fifo_ram.sv | 40 ++++
 rtl/ipml_pkt_fifo_sync.sv | 223 ++++++++++++++++++++++
 tb/tb_ipml_pkt_fifo_sync.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ipml_pkt_fifo_pkg.sv
// Shared definitions for the ipml_pkt_fifo_sync packet FIFO.
//   ptr_width() : pointer width for a given log2 depth (one extra wrap bit)
//   eop_bit()   : index of the EOP flag inside a stored RAM word (MSB)
//   wr_evt_e    : classification of what the write port does in a cycle
package ipml_pkt_fifo_pkg;

  // Pointers carry one extra bit so full (diff == D) and empty (diff == 0) differ.
  function automatic int unsigned ptr_width(input int unsigned depth_width);
    return depth_width + 1;
  endfunction

  // EOP sits just above the payload in each RAM word.
  function automatic int unsigned eop_bit(input int unsigned data_width);
    return data_width;
  endfunction

  typedef enum logic [2:0] {
    WrIdle,       // nothing happens on the write side
    WrPush,       // word stored, packet still open
    WrCommit,     // word stored and packet made visible to the reader
    WrRewind,     // writer drop: discard the open packet
    WrOvfLose,    // write while full: beat lost
    WrOvfRewind   // EOP of an overflowed packet: discard it and flag the drop
  } wr_evt_e;

endpackage

// File: rtl/ipml_pkt_fifo_ram.sv
// Simple dual-port RAM, single clock, registered read port.
//   clk     : clock
//   rst     : synchronous reset of the read data register only (array is not cleared)
//   wr_en   : write strobe, wr_addr/wr_data : write address and word
//   rd_en   : read strobe; rd_data updates one cycle later and holds otherwise
//   rd_addr : read address, rd_data : registered read word
module ipml_pkt_fifo_ram #(
  parameter int unsigned c_WIDTH      = 33,
  parameter int unsigned c_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [c_ADDR_WIDTH-1:0] wr_addr,
  input  logic [c_WIDTH-1:0]      wr_data,
  input  logic                    rd_en,
  input  logic [c_ADDR_WIDTH-1:0] rd_addr,
  output logic [c_WIDTH-1:0]      rd_data
);

  localparam int unsigned Depth = 1 << c_ADDR_WIDTH;

  logic [c_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register reset maps onto the RAM primitive's output-register reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ipml_pkt_fifo_sync.sv
// Single-clock packet FIFO with commit-at-EOP, writer drop and overflow rewind.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   wr_data/wr_en    : write payload and request
//   wr_eop           : current beat ends the packet
//   wr_drop          : discard the uncommitted packet (packet mode only)
//   wr_full          : no free word
//   almost_full      : wr_water_level >= c_ALMOST_FULL_NUM
//   wr_water_level   : words occupied, committed or not
//   wr_ovf_drop      : one-cycle pulse when a packet (or beat in stream mode) is lost
//   rd_data/rd_eop   : read word and its EOP flag
//   rd_valid         : rd_data/rd_eop valid
//   rd_en            : FWFT pop / standard read request
//   rd_empty         : nothing committed available to the read interface
//   almost_empty     : rd_water_level <= c_ALMOST_EMPTY_NUM
//   rd_water_level   : committed words still in RAM
//   pkt_count        : committed packets whose EOP has not left the read port
module ipml_pkt_fifo_sync
  import ipml_pkt_fifo_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH       = 32,
  parameter int unsigned c_DEPTH_WIDTH      = 10,
  parameter int unsigned c_PKT_MODE         = 1,
  parameter int unsigned c_FWFT             = 1,
  parameter int unsigned c_ALMOST_FULL_NUM  = (1 << c_DEPTH_WIDTH) - 8,
  parameter int unsigned c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [c_DATA_WIDTH-1:0]  wr_data,
  input  logic                     wr_en,
  input  logic                     wr_eop,
  input  logic                     wr_drop,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [c_DEPTH_WIDTH:0]   wr_water_level,
  output logic                     wr_ovf_drop,
  output logic [c_DATA_WIDTH-1:0]  rd_data,
  output logic                     rd_eop,
  output logic                     rd_valid,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [c_DEPTH_WIDTH:0]   rd_water_level,
  output logic [c_DEPTH_WIDTH:0]   pkt_count
);

  localparam int unsigned PtrW  = ptr_width(c_DEPTH_WIDTH);
  localparam int unsigned EopB  = eop_bit(c_DATA_WIDTH);
  localparam int unsigned WordW = c_DATA_WIDTH + 1;
  localparam logic [PtrW-1:0] DepthP = PtrW'(1 << c_DEPTH_WIDTH);
  localparam bit PktMode = (c_PKT_MODE != 0);
  localparam bit Fwft    = (c_FWFT != 0);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic            bad_q, bad_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  logic [PtrW-1:0] wr_lvl, rd_lvl;
  logic            full;
  logic            wr_accept;
  logic            commit;
  logic            fetch;
  logic            pop;
  logic            eop_leave;
  wr_evt_e         wr_evt;
  logic [WordW-1:0] ram_q;

  // Levels and flags come straight from the registered pointers.
  assign wr_lvl = wr_ptr_q - rd_ptr_q;
  assign rd_lvl = cm_ptr_q - rd_ptr_q;
  assign full   = (wr_lvl == DepthP);

  assign wr_full        = full;
  assign almost_full    = 32'(wr_lvl) >= c_ALMOST_FULL_NUM;
  assign wr_water_level = wr_lvl;
  assign rd_water_level = rd_lvl;
  assign almost_empty   = 32'(rd_lvl) <= c_ALMOST_EMPTY_NUM;
  assign rd_empty       = Fwft ? !valid_q : (rd_lvl == '0);
  assign rd_valid       = valid_q;
  assign rd_data        = ram_q[c_DATA_WIDTH-1:0];
  assign rd_eop         = ram_q[EopB];
  assign wr_ovf_drop    = ovf_q;
  assign pkt_count      = pkt_cnt_q;

  // A drop beat is never stored; in stream mode wr_drop has no meaning.
  assign wr_accept = wr_en && !full && !(PktMode && wr_drop);

  // ---------------------------------------------------------------------------
  // Write side: classify the cycle, then derive pointer/flag updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_evt = WrIdle;
    if (PktMode) begin
      if (wr_drop) begin
        wr_evt = WrRewind;
      end else if (wr_en) begin
        if (full) begin
          // An EOP that arrives while full ends the overflowed packet right here.
          wr_evt = wr_eop ? WrOvfRewind : WrOvfLose;
        end else if (wr_eop) begin
          wr_evt = bad_q ? WrOvfRewind : WrCommit;
        end else begin
          wr_evt = WrPush;
        end
      end
    end else if (wr_en) begin
      if (full) begin
        wr_evt = WrOvfLose;
      end else begin
        wr_evt = wr_eop ? WrCommit : WrPush;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    bad_d    = bad_q;
    ovf_d    = 1'b0;
    commit   = 1'b0;
    unique case (wr_evt)
      WrPush: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      WrCommit: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        cm_ptr_d = wr_ptr_q + 1'b1;
        commit   = 1'b1;
      end
      WrRewind: begin
        wr_ptr_d = cm_ptr_q;
        bad_d    = 1'b0;
      end
      WrOvfLose: begin
        // Packet mode defers the drop report to the packet's EOP.
        if (PktMode) begin
          bad_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      WrOvfRewind: begin
        wr_ptr_d = cm_ptr_q;
        bad_d    = 1'b0;
        ovf_d    = 1'b1;
      end
      default: begin
      end
    endcase
    if (!PktMode) begin
      cm_ptr_d = wr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side. The RAM read register is the output stage: in FWFT mode it is
  // refilled whenever it is empty or being popped, giving 1 word/cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (Fwft) begin
      pop       = rd_en && valid_q;
      fetch     = (!valid_q || rd_en) && (rd_lvl != '0);
      valid_d   = fetch || (valid_q && !pop);
      eop_leave = pop && rd_eop;
    end else begin
      pop       = 1'b0;
      fetch     = rd_en && (rd_lvl != '0);
      valid_d   = fetch;
      // Standard mode: the EOP word leaves during its rd_valid cycle.
      eop_leave = valid_q && rd_eop;
    end
    rd_ptr_d = rd_ptr_q + PtrW'(fetch);
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    unique case ({commit, eop_leave})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      bad_q     <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      bad_q     <= bad_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  ipml_pkt_fifo_ram #(
    .c_WIDTH      (WordW),
    .c_ADDR_WIDTH (c_DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[c_DEPTH_WIDTH-1:0]),
    .wr_data ({wr_eop, wr_data}),
    .rd_en   (fetch),
    .rd_addr (rd_ptr_q[c_DEPTH_WIDTH-1:0]),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_ipml_pkt_fifo_sync.sv
module tb_ipml_pkt_fifo_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: packet mode, FWFT, depth 16
  logic [31:0] a_wr_data, a_rd_data;
  logic a_wr_en, a_wr_eop, a_wr_drop, a_rd_en;
  logic a_wr_full, a_af, a_ovf, a_rd_eop, a_rd_valid, a_rd_empty, a_ae;
  logic [4:0] a_wr_lvl, a_rd_lvl, a_pkt;
  // Instance B: stream mode, standard read, depth 16
  logic [31:0] b_wr_data, b_rd_data;
  logic b_wr_en, b_wr_eop, b_wr_drop, b_rd_en;
  logic b_wr_full, b_af, b_ovf, b_rd_eop, b_rd_valid, b_rd_empty, b_ae;
  logic [4:0] b_wr_lvl, b_rd_lvl, b_pkt;

  ipml_pkt_fifo_sync #(
    .c_DATA_WIDTH(32), .c_DEPTH_WIDTH(4), .c_PKT_MODE(1), .c_FWFT(1),
    .c_ALMOST_FULL_NUM(8), .c_ALMOST_EMPTY_NUM(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .wr_data(a_wr_data), .wr_en(a_wr_en), .wr_eop(a_wr_eop),
    .wr_drop(a_wr_drop), .wr_full(a_wr_full), .almost_full(a_af), .wr_water_level(a_wr_lvl),
    .wr_ovf_drop(a_ovf), .rd_data(a_rd_data), .rd_eop(a_rd_eop), .rd_valid(a_rd_valid),
    .rd_en(a_rd_en), .rd_empty(a_rd_empty), .almost_empty(a_ae), .rd_water_level(a_rd_lvl),
    .pkt_count(a_pkt)
  );

  ipml_pkt_fifo_sync #(
    .c_DATA_WIDTH(32), .c_DEPTH_WIDTH(4), .c_PKT_MODE(0), .c_FWFT(0),
    .c_ALMOST_FULL_NUM(8), .c_ALMOST_EMPTY_NUM(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .wr_data(b_wr_data), .wr_en(b_wr_en), .wr_eop(b_wr_eop),
    .wr_drop(b_wr_drop), .wr_full(b_wr_full), .almost_full(b_af), .wr_water_level(b_wr_lvl),
    .wr_ovf_drop(b_ovf), .rd_data(b_rd_data), .rd_eop(b_rd_eop), .rd_valid(b_rd_valid),
    .rd_en(b_rd_en), .rd_empty(b_rd_empty), .almost_empty(b_ae), .rd_water_level(b_rd_lvl),
    .pkt_count(b_pkt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard model of instance A: open packet words, committed words, output stage.
  logic [32:0] pend_q[$];
  logic [32:0] cm_q[$];
  logic [32:0] m_out;
  logic m_bad, m_valid, m_ovf;
  int m_pkt;

  task automatic model_reset();
    pend_q.delete();
    cm_q.delete();
    m_out = '0;
    m_bad = 1'b0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_pkt = 0;
  endtask

  task automatic a_check_state();
    int wl;
    int rl;
    wl = cm_q.size() + pend_q.size();
    rl = cm_q.size();
    check_eq("a_wr_lvl", 64'(a_wr_lvl), 64'(wl));
    check_eq("a_rd_lvl", 64'(a_rd_lvl), 64'(rl));
    check_eq("a_wr_full", 64'(a_wr_full), 64'(wl == 16));
    check_eq("a_almost_full", 64'(a_af), 64'(wl >= 8));
    check_eq("a_almost_empty", 64'(a_ae), 64'(rl <= 4));
    check_eq("a_rd_valid", 64'(a_rd_valid), 64'(m_valid));
    check_eq("a_rd_empty", 64'(a_rd_empty), 64'(!m_valid));
    check_eq("a_pkt_count", 64'(a_pkt), 64'(m_pkt));
    check_eq("a_ovf_drop", 64'(a_ovf), 64'(m_ovf));
    if (m_valid) check_eq("a_rd_word", 64'({a_rd_eop, a_rd_data}), 64'(m_out));
  endtask

  task automatic cyc_a(input logic [31:0] d, input logic en, input logic eop,
                       input logic drop, input logic rden);
    logic full, pop, fetch, commit;
    a_wr_data = d; a_wr_en = en; a_wr_eop = eop; a_wr_drop = drop; a_rd_en = rden;
    full   = ((cm_q.size() + pend_q.size()) == 16);
    pop    = rden && m_valid;
    fetch  = (!m_valid || pop) && (cm_q.size() > 0);
    m_ovf  = 1'b0;
    commit = 1'b0;
    if (pop && m_out[32]) m_pkt--;
    if (fetch) begin
      m_out = cm_q.pop_front();
      m_valid = 1'b1;
    end else if (pop) begin
      m_valid = 1'b0;
    end
    if (drop) begin
      pend_q.delete();
      m_bad = 1'b0;
    end else if (en) begin
      if (full) begin
        if (eop) begin
          pend_q.delete(); m_bad = 1'b0; m_ovf = 1'b1;
        end else begin
          m_bad = 1'b1;
        end
      end else begin
        pend_q.push_back({eop, d});
        if (eop) begin
          if (m_bad) begin
            pend_q.delete(); m_bad = 1'b0; m_ovf = 1'b1;
          end else begin
            commit = 1'b1;
          end
        end
      end
    end
    if (commit) begin
      m_pkt++;
      while (pend_q.size() > 0) cm_q.push_back(pend_q.pop_front());
    end
    @(posedge clk); #1;
    a_check_state();
  endtask

  task automatic a_drain();
    for (int k = 0; k < 64 && (cm_q.size() > 0 || m_valid); k++) cyc_a(32'h0, 0, 0, 0, 1);
    check_eq("a_drained", 64'(a_rd_empty), 64'd1);
  endtask

  task automatic cyc_b(input logic [31:0] d, input logic en, input logic eop,
                       input logic drop, input logic rden);
    b_wr_data = d; b_wr_en = en; b_wr_eop = eop; b_wr_drop = drop; b_rd_en = rden;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    a_wr_data = '0; a_wr_en = 0; a_wr_eop = 0; a_wr_drop = 0; a_rd_en = 0;
    b_wr_data = '0; b_wr_en = 0; b_wr_eop = 0; b_wr_drop = 0; b_rd_en = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    a_check_state();
    check_eq("a_rst_rd_data", 64'({a_rd_eop, a_rd_data}), 64'd0);
    check_eq("b_rst_wr_lvl", 64'(b_wr_lvl), 64'd0);
    check_eq("b_rst_rd_empty", 64'(b_rd_empty), 64'd1);
    check_eq("b_rst_pkt", 64'(b_pkt), 64'd0);
  endtask

  initial begin
    do_reset();

    // Stream mode, standard read: read on empty ignored, 1-cycle latency, drop ignored.
    cyc_b(32'h0, 0, 0, 0, 1);
    check_eq("b_empty_rd_valid", 64'(b_rd_valid), 64'd0);
    check_eq("b_empty_rd_lvl", 64'(b_rd_lvl), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc_b(32'(100 + i), 1, (i == 4), (i == 2), 0);
      check_eq("b_wr_rd_lvl", 64'(b_rd_lvl), 64'(i + 1));
      check_eq("b_wr_wr_lvl", 64'(b_wr_lvl), 64'(i + 1));
    end
    check_eq("b_pkt_after_wr", 64'(b_pkt), 64'd1);
    check_eq("b_rd_empty_lo", 64'(b_rd_empty), 64'd0);
    check_eq("b_almost_empty_lo", 64'(b_ae), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc_b(32'h0, 0, 0, 0, 1);
      check_eq("b_rd_valid", 64'(b_rd_valid), 64'd1);
      check_eq("b_rd_data", 64'(b_rd_data), 64'(100 + i));
      check_eq("b_rd_eop", 64'(b_rd_eop), 64'(i == 4));
      check_eq("b_rd_lvl", 64'(b_rd_lvl), 64'(4 - i));
    end
    cyc_b(32'h0, 0, 0, 0, 1);
    check_eq("b_6th_rd_valid", 64'(b_rd_valid), 64'd0);
    check_eq("b_6th_rd_data_hold", 64'(b_rd_data), 64'd104);
    check_eq("b_6th_pkt", 64'(b_pkt), 64'd0);
    for (int i = 0; i < 16; i++) cyc_b(32'(200 + i), 1, 0, 0, 0);
    check_eq("b_full", 64'(b_wr_full), 64'd1);
    check_eq("b_ovf_before", 64'(b_ovf), 64'd0);
    cyc_b(32'h999, 1, 0, 0, 0);
    check_eq("b_ovf_pulse", 64'(b_ovf), 64'd1);
    check_eq("b_full_lvl", 64'(b_wr_lvl), 64'd16);
    cyc_b(32'h0, 0, 0, 0, 0);
    check_eq("b_ovf_clear", 64'(b_ovf), 64'd0);
    cyc_b(32'h0, 0, 0, 0, 1);
    check_eq("b_after_full_data", 64'(b_rd_data), 64'd200);
    check_eq("b_after_full_wr_full", 64'(b_wr_full), 64'd0);
    b_rd_en = 0;

    // FWFT: A,B,C packet; visible only after commit, then three pops.
    cyc_a(32'hA, 1, 0, 0, 0);
    cyc_a(32'hB, 1, 0, 0, 0);
    cyc_a(32'hC, 1, 1, 0, 0);
    check_eq("t1_valid_lo", 64'(a_rd_valid), 64'd0);
    check_eq("t1_pkt1", 64'(a_pkt), 64'd1);
    cyc_a(32'h0, 0, 0, 0, 0);
    check_eq("t1_valid_hi", 64'(a_rd_valid), 64'd1);
    check_eq("t1_first", 64'({a_rd_eop, a_rd_data}), 64'hA);
    for (int i = 0; i < 3; i++) cyc_a(32'h0, 0, 0, 0, 1);
    check_eq("t1_pkt0", 64'(a_pkt), 64'd0);

    // Writer drop, then a clean packet.
    cyc_a(32'h11, 1, 0, 0, 0);
    cyc_a(32'h12, 1, 0, 0, 0);
    cyc_a(32'h13, 1, 1, 1, 0);
    check_eq("t2_lvl0", 64'(a_wr_lvl), 64'd0);
    check_eq("t2_empty", 64'(a_rd_empty), 64'd1);
    cyc_a(32'hD, 1, 0, 0, 0);
    cyc_a(32'hE, 1, 1, 0, 0);
    a_drain();

    // Oversized packet: overflow, rewind at EOP, nothing readable.
    for (int i = 0; i < 20; i++) begin
      cyc_a(32'(500 + i), 1, (i == 19), 0, 0);
      if (i == 15) check_eq("t3_full", 64'(a_wr_full), 64'd1);
    end
    check_eq("t3_ovf", 64'(a_ovf), 64'd1);
    check_eq("t3_lvl0", 64'(a_wr_lvl), 64'd0);
    repeat (3) cyc_a(32'h0, 0, 0, 0, 0);
    check_eq("t3_no_data", 64'(a_rd_valid), 64'd0);

    // Full 16-word packet, then random concurrent traffic against the scoreboard.
    for (int i = 0; i < 16; i++) cyc_a(32'(300 + i), 1, (i == 15), 0, 0);
    check_eq("t4_full", 64'(a_wr_full), 64'd1);
    cyc_a(32'h400, 1, 0, 0, 1);
    cyc_a(32'h401, 1, 1, 0, 1);
    for (int i = 0; i < 100; i++) begin
      cyc_a($urandom, ($urandom_range(3) != 0), ($urandom_range(3) == 0),
            ($urandom_range(15) == 0), $urandom_range(1) == 1);
    end
    cyc_a(32'h0, 1, 1, 1, 0);
    a_drain();

    // Reset with committed packets and one open packet present.
    cyc_a(32'h21, 1, 0, 0, 0);
    cyc_a(32'h22, 1, 1, 0, 0);
    cyc_a(32'h23, 1, 0, 0, 0);
    cyc_a(32'h24, 1, 1, 0, 0);
    cyc_a(32'h25, 1, 0, 0, 0);
    do_reset();
    check_eq("t6_pkt0", 64'(a_pkt), 64'd0);
    check_eq("t6_empty", 64'(a_rd_empty), 64'd1);
    cyc_a(32'h31, 1, 0, 0, 0);
    cyc_a(32'h32, 1, 0, 0, 0);
    cyc_a(32'h33, 1, 1, 0, 0);
    a_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
